// File: rtl/spi_link_core_if.sv
// Pin-side bundle for spi_link_core: serial MOSI/cs in, MISO echo out, lds word, rdy/dn/start handshake.
// The core sits on the slave modport; the pin/driver side uses the master modport.
interface spi_link_core_if;
    logic       MOSI;
    logic       cs;
    logic       rdy;
    logic       dn;
    logic       MISO;
    logic [3:0] lds;
    logic       start;

    modport master (
        output MOSI,
        output cs,
        output rdy,
        output dn,
        input  MISO,
        input  lds,
        input  start
    );

    modport slave (
        input  MOSI,
        input  cs,
        input  rdy,
        input  dn,
        output MISO,
        output lds,
        output start
    );
endinterface

// File: rtl/spi_link_core.sv
// spi_link_core: cs-gated MOSI shifted MSB-first into lds, MISO echo, rdy/dn start handshake.
// Latency: MISO/lds[0]/start 1 clk, lds[3] 4 clk; no backpressure, every edge shifts.
module spi_link_core (
    input  logic                 clk,
    input  logic                 rst,
    spi_link_core_if.slave       bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } hs_state_t;

    hs_state_t  state;
    hs_state_t  state_nxt;
    logic       mosi_g;
    logic [3:0] lds_q;
    logic       miso_q;

    // While deselected the datapath sees zeros, so lds drains within 4 edges.
    assign mosi_g = ~bus.cs & bus.MOSI;

    always_ff @(posedge clk) begin
        if (rst) begin
            lds_q  <= 4'b0000;
            miso_q <= 1'b0;
        end else begin
            lds_q  <= {lds_q[2:0], mosi_g};
            miso_q <= mosi_g;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // rdy is only looked at in IDLE and dn only in RUN, so rdy wins when both arrive in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.rdy) state_nxt = RUN;
            RUN:  if (bus.dn)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.lds   = lds_q;
    assign bus.MISO  = miso_q;
    assign bus.start = (state == RUN);

endmodule

// File: tb/tb_spi_link_core.sv
// Directed bench for spi_link_core: reset, serial load, cs gating, handshake, reset mid-operation.
module tb_spi_link_core;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    spi_link_core_if sif ();

    spi_link_core dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle to a sampling point away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] load_lds  [4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
    logic       load_mosi [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] gate_lds  [4] = '{4'b0110, 4'b1100, 4'b1000, 4'b0000};

    initial begin
        checks = 0;
        errors = 0;
        rst      = 1'b1;
        sif.MOSI = 1'b1;
        sif.cs   = 1'b0;
        sif.rdy  = 1'b1;
        sif.dn   = 1'b0;

        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_lds",   sif.lds,          4'b0000);
            chk("rst_miso",  {3'b0, sif.MISO}, 4'd0);
            chk("rst_start", {3'b0, sif.start}, 4'd0);
        end

        // Serial load, first edge after reset release
        rst     = 1'b0;
        sif.rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sif.MOSI = load_mosi[i];
            step();
            chk("load_lds",  sif.lds,          load_lds[i]);
            chk("load_miso", {3'b0, sif.MISO}, {3'b0, load_mosi[i]});
        end
        chk("load_start", {3'b0, sif.start}, 4'd0);

        // Chip-select gating
        sif.cs   = 1'b1;
        sif.MOSI = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("gate_lds",  sif.lds,          gate_lds[i]);
            chk("gate_miso", {3'b0, sif.MISO}, 4'd0);
        end

        // Handshake: rdy pulse, rdy pulse in RUN ignored, dn three cycles later
        sif.cs   = 1'b0;
        sif.MOSI = 1'b0;
        sif.rdy  = 1'b1;
        step(); chk("hs_rise",    {3'b0, sif.start}, 4'd1);
        sif.rdy = 1'b0;
        step(); chk("hs_hold1",   {3'b0, sif.start}, 4'd1);
        sif.rdy = 1'b1;
        step(); chk("hs_rdy_run", {3'b0, sif.start}, 4'd1);
        sif.rdy = 1'b0;
        sif.dn  = 1'b1;
        step(); chk("hs_fall",    {3'b0, sif.start}, 4'd0);
        sif.dn  = 1'b0;
        step(); chk("hs_idle",    {3'b0, sif.start}, 4'd0);

        // Simultaneous rdy/dn
        sif.rdy = 1'b1;
        sif.dn  = 1'b1;
        step(); chk("sim_idle_rdy_wins", {3'b0, sif.start}, 4'd1);
        step(); chk("sim_run_dn",        {3'b0, sif.start}, 4'd0);
        step(); chk("sim_idle_again",    {3'b0, sif.start}, 4'd1);

        // Steady rdy with a 1-cycle dn pulse
        sif.dn = 1'b0;
        step(); chk("steady_run",  {3'b0, sif.start}, 4'd1);
        sif.dn = 1'b1;
        step(); chk("steady_drop", {3'b0, sif.start}, 4'd0);
        sif.dn = 1'b0;
        step(); chk("steady_back", {3'b0, sif.start}, 4'd1);

        // Reset mid-operation: load 1011 while in RUN
        sif.rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sif.MOSI = load_mosi[i];
            step();
        end
        chk("mid_lds_pre",   sif.lds,           4'b1011);
        chk("mid_start_pre", {3'b0, sif.start}, 4'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_lds",   sif.lds,           4'b0000);
        chk("mid_rst_start", {3'b0, sif.start}, 4'd0);
        chk("mid_rst_miso",  {3'b0, sif.MISO},  4'd0);
        rst      = 1'b0;
        sif.MOSI = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_idle", {3'b0, sif.start}, 4'd0);
        end
        sif.rdy = 1'b1;
        step();
        chk("post_rst_rdy", {3'b0, sif.start}, 4'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_link_core.md
# spi_link_core

Receive-side core of the FPGA SPI slave link. It gates the incoming serial MOSI stream with chip-select and shifts it into a 4-bit parallel LED/control word (`lds`). It echoes the gated bit back on MISO one clock later. A separate ready/done handshake FSM generates the `start` control to the downstream application. The block sits directly behind the board SPI pins; `lds` also feeds the external PWM/speed logic, which is outside this block.

## Interface
Parameters:
- none. The width is fixed at 4 bits.

Ports:
- `clk`  input  1  single system/SPI sample clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `MOSI`  input  1  serial data from the master.
- `cs`  input  1  chip select, active-low.
- `rdy`  input  1  application ready request.
- `dn`  input  1  application done indication.
- `MISO`  output  1  registered echo of gated MOSI.
- `lds`  output  4  parallel shift-register contents.
- `start`  output  1  registered handshake output.

## Operation
- Gated data: `mosi_g = ~cs & MOSI`. While `cs`=1, the datapath sees 0.
- Shift register: every rising edge, `lds <= {lds[2:0], mosi_g}`.
  - Shifting is MSB-first: the first bit received ends up in `lds[3]` after 4 edges.
  - Shifting is continuous. There is no bit counter and no hold.
  - With `cs` high, zeros shift in, so `lds` clears after 4 edges.
- Echo flop: every rising edge, `MISO <= mosi_g`.
- Handshake FSM has two states, IDLE and RUN, and is fully registered.
  - IDLE: `start`=0. If `rdy`=1, go to RUN. `dn` is ignored.
  - RUN: `start`=1. If `dn`=1, go to IDLE. `rdy` is ignored.
  - `start` is asserted exactly while the FSM is in RUN, with `start` = (state==RUN).
  - `rdy` and `dn` both high in IDLE: go to RUN, because `rdy` wins.
  - `rdy` and `dn` both high in RUN: go to IDLE.
  - `rdy` held high continuously with `dn` pulsing: the FSM alternates RUN→IDLE→RUN, so `start` drops for exactly one cycle after each `dn`.
- No combinational path from any input to any output.

## Timing
- Reset (synchronous): on any edge with `rst`=1:
  - `lds`=4'b0000, `MISO`=0, FSM=IDLE, `start`=0.
  - Reset overrides shift, echo and FSM updates on that edge.
- Reset mid-operation:
  - Partially shifted data is discarded.
  - A RUN handshake aborts to IDLE without requiring `dn`.
- Latencies:
  - `MISO`: 1 clock from `MOSI`/`cs`.
  - `lds[0]`: 1 clock; `lds[3]`: 4 clocks.
  - `start` rises 1 clock after `rdy` is sampled high in IDLE.
  - `start` falls 1 clock after `dn` is sampled high in RUN.
- A `cs` change takes effect on the same edge that samples it. Bits presented while `cs`=1 are recorded as 0.
- The first edge after reset deassertion performs a normal shift/echo/FSM update.

## Test plan
- Reset: hold `rst`=1 for 2 clocks with `MOSI`=1, `cs`=0, `rdy`=1. Required: `lds`=0000, `MISO`=0, `start`=0 on each of those edges.
- Serial load: `cs`=0, send `MOSI`=1,0,1,1 on 4 consecutive edges.
  - Required `lds` after each edge: 0001, 0010, 0101, 1011.
  - Required `MISO` after each edge: 1, 0, 1, 1.
- Chip-select gating: load 1011, then set `cs`=1 with `MOSI`=1 for 4 edges. Required: `MISO`=0 throughout; `lds` = 0110, 1100, 1000, 0000.
- Handshake: pulse `rdy` for 1 cycle, then raise `dn` 3 cycles later. Required: `start`=1 from the edge after `rdy` through the edge that samples `dn`, then 0. `rdy` pulses during RUN do not change `start`.
- Simultaneous and steady requests:
  - `rdy`=`dn`=1 in IDLE → `start`=1 next edge.
  - `rdy` held high with a 1-cycle `dn` → `start` = 1, 0, 1 on successive edges.
- Reset mid-operation: `rst` asserted while in RUN and with `lds`=1011 → next edge `start`=0, `lds`=0000. After release, `start` stays 0 until `rdy`.
